tcdm_mux: RTL and testbench

N-to-1 TCDM request multiplexer with response routing: arbitrates requests from `NR_INPUTS` initiators onto one downstream TCDM slave and returns each read response to the initiator that issued it. It is the converging counterpart of the address-decoding demux and sits in front of shared memory banks or shared peripherals. It supports one outstanding read, with back-to-back issue on the response handshake cycle.

---
 rtl/tcdm_mux_pkg.sv | 25 ++
 rtl/tcdm_mux_if.sv | 29 ++
 rtl/tcdm_mux_rr_arbiter.sv | 50 +++++
 rtl/tcdm_mux.sv | 183 ++++++++++++++++++
 tb/tb_tcdm_mux.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tcdm_mux_pkg.sv
// Shared types and helpers for the TCDM N-to-1 request multiplexer.
// Optional feature macro: TCDM_MUX_RR_EN (round-robin arbitration).
package tcdm_mux_pkg;

   // Response-tracking FSM: at most one read is outstanding downstream.
   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } tcdm_mux_state_e;

   // Modular add of two indices; both operands are expected to be below n.
   function automatic logic [31:0] wrap_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] n);
      logic [31:0] sum;
      sum = a + b;
      if (sum >= n) begin
         sum = sum - n;
      end else begin
         sum = sum;
      end
      return sum;
   endfunction

endpackage

// File: rtl/tcdm_mux_if.sv
// TCDM request/response bundle shared between initiators, the mux and the slave.
// Optional feature macro: TCDM_MUX_RR_EN (not used in this file).
interface tcdm_mux_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
);
   logic                  req;
   logic                  gnt;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  wen;
   logic [DATA_WIDTH-1:0] data;
   logic [BE_WIDTH-1:0]   be;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  r_ready;

   // Side that issues requests and consumes responses.
   modport master (
      output req, addr, wen, data, be, r_ready,
      input  gnt, r_data, r_valid
   );

   // Side that accepts requests and produces responses.
   modport slave (
      input  req, addr, wen, data, be, r_ready,
      output gnt, r_data, r_valid
   );
endinterface

// File: rtl/tcdm_mux_rr_arbiter.sv
// Combinational winner selection for the TCDM mux.
// Optional feature macro: TCDM_MUX_RR_EN. Defined: search starts at rr_i and
// wraps. Undefined: fixed priority, lowest requesting index wins.
// A held lock overrides the search and forwards only lock_idx_i.
module tcdm_mux_rr_arbiter
   import tcdm_mux_pkg::*;
#(
   parameter  int unsigned NR_INPUTS = 2,
   localparam int unsigned SEL_WIDTH = $clog2(NR_INPUTS)
) (
   input  logic [NR_INPUTS-1:0] req_i,
   input  logic [SEL_WIDTH-1:0] rr_i,
   input  logic                 lock_i,
   input  logic [SEL_WIDTH-1:0] lock_idx_i,
   output logic [SEL_WIDTH-1:0] idx_o,
   output logic                 valid_o
);

   logic [SEL_WIDTH-1:0] base_s;
   logic [SEL_WIDTH-1:0] cand_s;
   logic                 hit_s;

`ifdef TCDM_MUX_RR_EN
   assign base_s = rr_i;
`else
   logic unused_rr_s;
   assign base_s      = {SEL_WIDTH{1'b0}};
   assign unused_rr_s = ^rr_i;
`endif

   // Pick the locked index, or the first requester at or after base_s.
   always_comb begin
      idx_o   = {SEL_WIDTH{1'b0}};
      valid_o = 1'b0;
      cand_s  = {SEL_WIDTH{1'b0}};
      hit_s   = 1'b0;
      if (lock_i) begin
         idx_o   = lock_idx_i;
         valid_o = req_i[lock_idx_i];
      end else begin
         for (int unsigned k = 0; k < NR_INPUTS; k++) begin
            cand_s  = SEL_WIDTH'(wrap_add(32'(base_s), k, NR_INPUTS));
            hit_s   = !valid_o && req_i[cand_s];
            idx_o   = hit_s ? cand_s : idx_o;
            valid_o = valid_o | hit_s;
         end
      end
   end

endmodule

// File: rtl/tcdm_mux.sv
// N-to-1 TCDM request multiplexer with read-response routing.
// One read may be outstanding; a new request may issue on the cycle the
// outstanding response handshakes. A request stalled by the slave is locked
// so no other initiator can overtake it before it is granted.
// Optional feature macro: TCDM_MUX_RR_EN (round-robin instead of fixed priority).
module tcdm_mux
   import tcdm_mux_pkg::*;
#(
   parameter int unsigned NR_INPUTS  = 2,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   tcdm_mux_if.slave         master_ports [NR_INPUTS],
   tcdm_mux_if.master        slave_port
);

   localparam int unsigned SEL_WIDTH = $clog2(NR_INPUTS);

   // Flattened view of the initiator ports.
   logic [NR_INPUTS-1:0]  mreq_s;
   logic [NR_INPUTS-1:0]  mwen_s;
   logic [NR_INPUTS-1:0]  mrready_s;
   logic [ADDR_WIDTH-1:0] maddr_s   [NR_INPUTS];
   logic [DATA_WIDTH-1:0] mdata_s   [NR_INPUTS];
   logic [BE_WIDTH-1:0]   mbe_s     [NR_INPUTS];
   logic [NR_INPUTS-1:0]  mgnt_s;
   logic [NR_INPUTS-1:0]  mrvalid_s;
   logic [DATA_WIDTH-1:0] mrdata_s  [NR_INPUTS];

   // Control state.
   tcdm_mux_state_e      state_q, state_d;
   logic [SEL_WIDTH-1:0] active_q, active_d;
   logic                 lock_q, lock_d;
   logic [SEL_WIDTH-1:0] lock_idx_q, lock_idx_d;
   logic [SEL_WIDTH-1:0] rr_s;

   // Datapath / handshake terms.
   logic [SEL_WIDTH-1:0] sel_s;
   logic                 sel_valid_s;
   logic                 r_ready_s;
   logic                 rsp_hs_s;
   logic                 issue_ok_s;
   logic                 req_s;
   logic                 grant_s;

   for (genvar g = 0; g < NR_INPUTS; g++) begin : g_port
      assign mreq_s[g]               = master_ports[g].req;
      assign mwen_s[g]               = master_ports[g].wen;
      assign mrready_s[g]            = master_ports[g].r_ready;
      assign maddr_s[g]              = master_ports[g].addr;
      assign mdata_s[g]              = master_ports[g].data;
      assign mbe_s[g]                = master_ports[g].be;
      assign master_ports[g].gnt     = mgnt_s[g];
      assign master_ports[g].r_valid = mrvalid_s[g];
      assign master_ports[g].r_data  = mrdata_s[g];
   end

   tcdm_mux_rr_arbiter #(
      .NR_INPUTS (NR_INPUTS)
   ) u_arb (
      .req_i      (mreq_s),
      .rr_i       (rr_s),
      .lock_i     (lock_q),
      .lock_idx_i (lock_idx_q),
      .idx_o      (sel_s),
      .valid_o    (sel_valid_s)
   );

   // Downstream request fields always follow the selected initiator.
   assign slave_port.req     = req_s;
   assign slave_port.addr    = maddr_s[sel_s];
   assign slave_port.wen     = mwen_s[sel_s];
   assign slave_port.data    = mdata_s[sel_s];
   assign slave_port.be      = mbe_s[sel_s];
   assign slave_port.r_ready = r_ready_s;

   // Issue gating, grant fan-out and response routing to the active initiator.
   always_comb begin
      r_ready_s  = 1'b0;
      mgnt_s     = {NR_INPUTS{1'b0}};
      mrvalid_s  = {NR_INPUTS{1'b0}};
      for (int unsigned i = 0; i < NR_INPUTS; i++) begin
         mrdata_s[i] = {DATA_WIDTH{1'b0}};
      end
      if (state_q == PENDING) begin
         r_ready_s = mrready_s[active_q];
      end else begin
         r_ready_s = 1'b0;
      end
      rsp_hs_s   = (state_q == PENDING) && slave_port.r_valid && r_ready_s;
      issue_ok_s = (state_q == IDLE) || rsp_hs_s;
      req_s      = sel_valid_s && issue_ok_s;
      grant_s    = req_s && slave_port.gnt;
      for (int unsigned i = 0; i < NR_INPUTS; i++) begin
         mgnt_s[i] = grant_s && (sel_s == SEL_WIDTH'(i));
         if ((state_q == PENDING) && (active_q == SEL_WIDTH'(i))) begin
            mrvalid_s[i] = slave_port.r_valid;
            mrdata_s[i]  = slave_port.r_data;
         end else begin
            mrvalid_s[i] = 1'b0;
            mrdata_s[i]  = {DATA_WIDTH{1'b0}};
         end
      end
   end

   // Next-state: response completion, new grants and lock bookkeeping.
   always_comb begin
      state_d    = state_q;
      active_d   = active_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      case (state_q)
         IDLE: begin
            state_d = IDLE;
         end
         PENDING: begin
            if (rsp_hs_s) begin
               state_d = IDLE;
            end else begin
               state_d = PENDING;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (grant_s) begin
         state_d  = mwen_s[sel_s] ? IDLE : PENDING;
         active_d = sel_s;
         lock_d   = 1'b0;
      end else if (req_s) begin
         lock_d     = 1'b1;
         lock_idx_d = sel_s;
      end else begin
         lock_d = lock_q;
      end
   end

   // FSM, active initiator and lock registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         active_q   <= {SEL_WIDTH{1'b0}};
         lock_q     <= 1'b0;
         lock_idx_q <= {SEL_WIDTH{1'b0}};
      end else begin
         state_q    <= state_d;
         active_q   <= active_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end

`ifdef TCDM_MUX_RR_EN
   logic [SEL_WIDTH-1:0] rr_q, rr_d;

   // Priority moves to the index just after the most recent grant.
   always_comb begin
      if (grant_s) begin
         rr_d = SEL_WIDTH'(wrap_add(32'(sel_s), 32'd1, NR_INPUTS));
      end else begin
         rr_d = rr_q;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q <= {SEL_WIDTH{1'b0}};
      end else begin
         rr_q <= rr_d;
      end
   end

   assign rr_s = rr_q;
`else
   assign rr_s = {SEL_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_tcdm_mux.sv
// Directed self-checking bench for tcdm_mux with two initiators.
// Expectations follow the build: TCDM_MUX_RR_EN selects round-robin results.
module tb_tcdm_mux;

   logic clk_s = 1'b0;
   logic rst_s;
   int   checks_s = 0;
   int   errors_s = 0;
   logic exp0_s;

   always #5 clk_s = ~clk_s;

   tcdm_mux_if m_if [2] ();
   tcdm_mux_if s_if ();

   tcdm_mux #(
      .NR_INPUTS  (2),
      .DATA_WIDTH (32),
      .BE_WIDTH   (4),
      .ADDR_WIDTH (32)
   ) dut (
      .clk_i        (clk_s),
      .rst_i        (rst_s),
      .master_ports (m_if),
      .slave_port   (s_if)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks_s++;
      assert (obs === exp_v) else begin
         errors_s++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic cyc();
      @(posedge clk_s);
      #1;
   endtask

   task automatic set_m0(input logic req, input logic wen, input logic [31:0] addr, input logic [31:0] data);
      m_if[0].req  = req;
      m_if[0].wen  = wen;
      m_if[0].addr = addr;
      m_if[0].data = data;
   endtask

   task automatic set_m1(input logic req, input logic wen, input logic [31:0] addr, input logic [31:0] data);
      m_if[1].req  = req;
      m_if[1].wen  = wen;
      m_if[1].addr = addr;
      m_if[1].data = data;
   endtask

   initial begin
      rst_s = 1'b1;
      set_m0(1'b0, 1'b0, 32'h0, 32'h0);
      set_m1(1'b0, 1'b0, 32'h0, 32'h0);
      m_if[0].be      = 4'hF;
      m_if[1].be      = 4'hF;
      m_if[0].r_ready = 1'b0;
      m_if[1].r_ready = 1'b0;
      s_if.gnt        = 1'b0;
      s_if.r_valid    = 1'b0;
      s_if.r_data     = 32'h0;
      cyc();
      cyc();
      rst_s = 1'b0;

      // Reset state, with a spurious downstream response present
      m_if[0].r_ready = 1'b1;
      m_if[1].r_ready = 1'b1;
      s_if.r_valid    = 1'b1;
      s_if.r_data     = 32'hFFFF;
      #2;
      chk("rst_s_req",    64'(s_if.req),        64'h0);
      chk("rst_s_rready", 64'(s_if.r_ready),    64'h0);
      chk("rst_gnt0",     64'(m_if[0].gnt),     64'h0);
      chk("rst_gnt1",     64'(m_if[1].gnt),     64'h0);
      chk("rst_rvalid0",  64'(m_if[0].r_valid), 64'h0);
      chk("rst_rvalid1",  64'(m_if[1].r_valid), 64'h0);
      m_if[0].r_ready = 1'b0;
      m_if[1].r_ready = 1'b0;
      s_if.r_valid    = 1'b0;
      s_if.r_data     = 32'h0;

      // Single write from input 1
      set_m1(1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
      s_if.gnt = 1'b1;
      #2;
      chk("wr_s_req",  64'(s_if.req),    64'h1);
      chk("wr_s_addr", 64'(s_if.addr),   64'h40);
      chk("wr_s_data", 64'(s_if.data),   64'hDEADBEEF);
      chk("wr_s_wen",  64'(s_if.wen),    64'h1);
      chk("wr_gnt1",   64'(m_if[1].gnt), 64'h1);
      chk("wr_gnt0",   64'(m_if[0].gnt), 64'h0);
      cyc();
      set_m1(1'b0, 1'b0, 32'h0, 32'h0);
      s_if.gnt        = 1'b0;
      m_if[0].r_ready = 1'b1;
      #2;
      chk("wr_idle_rready", 64'(s_if.r_ready), 64'h0);
      m_if[0].r_ready = 1'b0;

      // Read from input 0 with 3-cycle response latency
      set_m0(1'b1, 1'b0, 32'h10, 32'h0);
      s_if.gnt = 1'b1;
      #2;
      chk("rd_gnt0",   64'(m_if[0].gnt), 64'h1);
      chk("rd_s_wen",  64'(s_if.wen),    64'h0);
      chk("rd_s_addr", 64'(s_if.addr),   64'h10);
      cyc();
      set_m0(1'b0, 1'b0, 32'h0, 32'h0);
      set_m1(1'b1, 1'b1, 32'h80, 32'hCAFE);
      m_if[0].r_ready = 1'b1;
      m_if[1].r_ready = 1'b1;
      #2;
      chk("lat1_gnt1",    64'(m_if[1].gnt),     64'h0);
      chk("lat1_s_req",   64'(s_if.req),        64'h0);
      chk("lat1_rready",  64'(s_if.r_ready),    64'h1);
      chk("lat1_rvalid0", 64'(m_if[0].r_valid), 64'h0);
      cyc();
      #2;
      chk("lat2_gnt1", 64'(m_if[1].gnt), 64'h0);
      cyc();
      s_if.r_valid = 1'b1;
      s_if.r_data  = 32'h1234;
      #2;
      chk("lat3_rvalid0", 64'(m_if[0].r_valid), 64'h1);
      chk("lat3_rdata0",  64'(m_if[0].r_data),  64'h1234);
      chk("lat3_rvalid1", 64'(m_if[1].r_valid), 64'h0);
      chk("lat3_rdata1",  64'(m_if[1].r_data),  64'h0);
      chk("lat3_gnt1",    64'(m_if[1].gnt),     64'h1);
      chk("lat3_s_addr",  64'(s_if.addr),       64'h80);
      cyc();
      set_m1(1'b0, 1'b0, 32'h0, 32'h0);
      s_if.r_valid = 1'b0;
      s_if.r_data  = 32'h0;
      #2;
      chk("lat_idle_rready", 64'(s_if.r_ready), 64'h0);

      // Contention between two continuous writers
      set_m0(1'b1, 1'b1, 32'h100, 32'h1);
      set_m1(1'b1, 1'b1, 32'h104, 32'h2);
      s_if.gnt = 1'b1;
      for (int k = 0; k < 4; k++) begin
`ifdef TCDM_MUX_RR_EN
         exp0_s = ((k % 2) == 0);
`else
         exp0_s = 1'b1;
`endif
         #2;
         chk("arb_gnt0", 64'(m_if[0].gnt), 64'(exp0_s));
         chk("arb_gnt1", 64'(m_if[1].gnt), 64'(!exp0_s));
         cyc();
      end
      set_m0(1'b0, 1'b0, 32'h0, 32'h0);
      set_m1(1'b0, 1'b0, 32'h0, 32'h0);

      // Lock: input 1 stalled by the slave keeps the port over input 0
      s_if.gnt = 1'b0;
      set_m1(1'b1, 1'b1, 32'hC0, 32'h3);
      #2;
      chk("lk_a_s_req",  64'(s_if.req),    64'h1);
      chk("lk_a_s_addr", 64'(s_if.addr),   64'hC0);
      chk("lk_a_gnt1",   64'(m_if[1].gnt), 64'h0);
      cyc();
      set_m0(1'b1, 1'b1, 32'h0, 32'h4);
      #2;
      chk("lk_b_s_addr", 64'(s_if.addr),   64'hC0);
      chk("lk_b_gnt0",   64'(m_if[0].gnt), 64'h0);
      chk("lk_b_gnt1",   64'(m_if[1].gnt), 64'h0);
      cyc();
      s_if.gnt = 1'b1;
      #2;
      chk("lk_c_gnt1",   64'(m_if[1].gnt), 64'h1);
      chk("lk_c_gnt0",   64'(m_if[0].gnt), 64'h0);
      chk("lk_c_s_data", 64'(s_if.data),   64'h3);
      cyc();
      set_m1(1'b0, 1'b0, 32'h0, 32'h0);
      #2;
      chk("lk_d_gnt0",   64'(m_if[0].gnt), 64'h1);
      chk("lk_d_s_addr", 64'(s_if.addr),   64'h0);
      cyc();
      set_m0(1'b0, 1'b0, 32'h0, 32'h0);

      // Back-to-back reads from input 0
      set_m0(1'b1, 1'b0, 32'h20, 32'h0);
      m_if[0].r_ready = 1'b1;
      #2;
      chk("b2b_gnt0_first", 64'(m_if[0].gnt), 64'h1);
      cyc();
      set_m0(1'b1, 1'b0, 32'h24, 32'h0);
      #2;
      chk("b2b_wait_gnt0",  64'(m_if[0].gnt), 64'h0);
      chk("b2b_wait_s_req", 64'(s_if.req),    64'h0);
      cyc();
      s_if.r_valid = 1'b1;
      s_if.r_data  = 32'hAA;
      #2;
      chk("b2b_rvalid0", 64'(m_if[0].r_valid), 64'h1);
      chk("b2b_rdata0",  64'(m_if[0].r_data),  64'hAA);
      chk("b2b_gnt0",    64'(m_if[0].gnt),     64'h1);
      chk("b2b_s_addr",  64'(s_if.addr),       64'h24);
      cyc();
      set_m0(1'b0, 1'b0, 32'h0, 32'h0);
      s_if.r_valid = 1'b0;
      #2;
      chk("b2b_pend_rready", 64'(s_if.r_ready),    64'h1);
      chk("b2b_pend_rvalid", 64'(m_if[0].r_valid), 64'h0);
      cyc();
      s_if.r_valid = 1'b1;
      s_if.r_data  = 32'h55;
      #2;
      chk("b2b_rdata0_2", 64'(m_if[0].r_data), 64'h55);
      cyc();
      s_if.r_valid = 1'b0;
      s_if.r_data  = 32'h0;
      #2;
      chk("b2b_idle_rready", 64'(s_if.r_ready), 64'h0);

      // Reset while a read is outstanding
      set_m0(1'b1, 1'b0, 32'h30, 32'h0);
      #2;
      chk("rstp_gnt0", 64'(m_if[0].gnt), 64'h1);
      cyc();
      set_m0(1'b0, 1'b0, 32'h0, 32'h0);
      #2;
      chk("rstp_pend_rready", 64'(s_if.r_ready), 64'h1);
      rst_s = 1'b1;
      cyc();
      rst_s        = 1'b0;
      s_if.r_valid = 1'b1;
      s_if.r_data  = 32'h99;
      #2;
      chk("rstp_rvalid0", 64'(m_if[0].r_valid), 64'h0);
      chk("rstp_rvalid1", 64'(m_if[1].r_valid), 64'h0);
      chk("rstp_rdata0",  64'(m_if[0].r_data),  64'h0);
      chk("rstp_rready",  64'(s_if.r_ready),    64'h0);
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks_s, errors_s);
      $finish;
   end

endmodule
